sa_tile_sequencer: RTL and testbench
====================================

Name: sa_tile_sequencer

Overview:
Run-time controller for the 4x4 signed systolic array tile engine. On an ap_start pulse it walks the instruction memory and processes one tile per non-zero instruction. For each tile it fetches the tile size N, clears the array and the input-memory read pointers, and streams A/B columns for N+DRAIN cycles. It then commits the 16 accumulators to output memory. It signals completion on a zero instruction or after MAX_INSTR tiles.

Parameters:
MAX_INSTR, 8, instruction memory depth; tile slots in output memory
INSTR_W, 4, instruction (tile size N) width
DRAIN, 7, extra stream cycles to flush the array skew
CNT_W, 5, stream counter width; must hold (2^INSTR_W - 1) + DRAIN

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
ap_start  in  1  start pulse; sampled only in IDLE
instr_data  in  INSTR_W  instruction memory read data; valid one cycle after instr_rd
instr_rd  out  1  instruction memory read enable
instr_addr  out  clog2(MAX_INSTR)  instruction address (= tile pointer)
in_clr  out  1  resets A/B input-memory column counters
a_rd  out  1  A input-memory column read enable
b_rd  out  1  B input-memory column read enable
sa_clr  out  1  synchronous clear of all PE registers
out_wr  out  1  output-memory write of c0..c15
out_tile  out  clog2(MAX_INSTR)  tile slot for out_wr (base address = out_tile*16)
out_rd_en  out  1  enables host readback of output memory
busy  out  1  high in every state except IDLE
ap_done  out  1  level; set on entry to DONE; cleared by the next accepted ap_start or by reset

Behaviour:
- All outputs are registered. Reset (rst=0, asynchronous) forces IDLE, pointer=0, counter=0, and every output 0. Reset mid-tile abandons the tile without writing it.
- States and transitions:
  - IDLE: waits for ap_start=1. On start it clears ap_done and out_rd_en, sets pointer=0, and goes to FETCH. ap_start in any other state is ignored.
  - FETCH (1 cycle): instr_rd=1, instr_addr=pointer. Goes to DECODE.
  - DECODE (1 cycle): samples instr_data. If 0, goes to DONE. Otherwise loads counter=instr_data+DRAIN and goes to CLEAR.
  - CLEAR (1 cycle): sa_clr=1, in_clr=1. Goes to STREAM.
  - STREAM: a_rd=b_rd=1 for exactly counter cycles, decrementing each cycle. The cycle in which counter reaches 1 is the last read; then goes to WRITE.
  - WRITE (1 cycle): out_wr=1, out_tile=pointer. If pointer==MAX_INSTR-1, goes to DONE. Otherwise pointer+1 and goes to FETCH.
  - DONE (1 cycle): ap_done=1, out_rd_en=1. Goes to IDLE; ap_done and out_rd_en stay high.
- Per-tile latency is N+DRAIN+4 cycles: FETCH, DECODE, CLEAR, STREAM, WRITE.
- Arithmetic: the counter is unsigned CNT_W bits. INSTR_W-bit instr_data is zero-extended before adding DRAIN, so N=15 gives 22 with no overflow.
- Pointer wrap: never wraps. The MAX_INSTR limit ends the run.
- a_rd/b_rd are never high in the same cycle as sa_clr or out_wr.
- ap_start coinciding with DONE→IDLE is ignored; only IDLE samples it.

Decomposition:
- sa_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, CLEAR, STREAM, WRITE, DONE)
  - DRAIN, MAX_INSTR and INSTR_W defaults
  - derived widths for CNT_W and the pointer
- One sub-module: sa_stream_counter, a loadable down-counter with a last flag, used for STREAM timing.
- Everything else is in the single FSM module.

Test Plan:
- Instructions [4,0], one ap_start pulse: sequence below, then ap_done rises on the 17th rising edge after the start-sampling edge.
  - exactly 1 sa_clr pulse
  - 11 consecutive a_rd/b_rd cycles
  - 1 out_wr with out_tile=0
  - second fetch at addr 1
- Instructions [0,...]: ap_done after FETCH+DECODE, i.e. within 3 cycles of start; zero out_wr pulses; no a_rd.
- Instructions [2,15,3,0]: sequence below, then done at addr 3.
  - out_wr pulses with out_tile 0,1,2
  - stream lengths 9, 22, 10 counted cycle-exact
- All 8 instructions =1: 8 out_wr pulses (out_tile 0..7); DONE entered after the WRITE of tile 7 with no fetch of addr 8.
- ap_start re-pulsed mid-STREAM: no effect on state or counter. A later pulse in IDLE clears ap_done and restarts from addr 0.
- rst driven low asynchronously mid-STREAM of tile 1: all outputs 0 immediately, no out_wr for tile 1. After release and ap_start, the run restarts at addr 0.

Source files
------------

// File: rtl/sa_tile_sequencer_pkg.sv
// Shared types and sizing for the systolic-array tile sequencer.
// Counter width is derived so the longest tile (max N plus drain) never overflows.
package sa_tile_sequencer_pkg;

    localparam int MAX_INSTR = 8;
    localparam int INSTR_W   = 4;
    localparam int DRAIN     = 7;
    localparam int CNT_W     = $clog2((2**INSTR_W - 1) + DRAIN + 1);
    localparam int PTR_W     = $clog2(MAX_INSTR);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        CLEAR,
        STREAM,
        WRITE,
        DONE
    } state_t;

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Zero-extend N before adding the drain so N=15 yields 22, not a wrapped value.
    function automatic cnt_t tile_len(input instr_t n);
        return cnt_t'(n) + cnt_t'(DRAIN);
    endfunction

endpackage

// File: rtl/sa_tile_sequencer_if.sv
// Control/memory-strobe bundle between the host side and the tile sequencer.
// master = host/memories side, slave = sequencer.
interface sa_tile_sequencer_if;
    import sa_tile_sequencer_pkg::*;

    logic   ap_start;
    instr_t instr_data;
    logic   instr_rd;
    ptr_t   instr_addr;
    logic   in_clr;
    logic   a_rd;
    logic   b_rd;
    logic   sa_clr;
    logic   out_wr;
    ptr_t   out_tile;
    logic   out_rd_en;
    logic   busy;
    logic   ap_done;

    modport master (
        output ap_start, instr_data,
        input  instr_rd, instr_addr, in_clr, a_rd, b_rd, sa_clr,
               out_wr, out_tile, out_rd_en, busy, ap_done
    );

    modport slave (
        input  ap_start, instr_data,
        output instr_rd, instr_addr, in_clr, a_rd, b_rd, sa_clr,
               out_wr, out_tile, out_rd_en, busy, ap_done
    );

endinterface

// File: rtl/sa_tile_sequencer_stream_counter.sv
// Loadable down-counter timing the STREAM phase; o_last flags the final read cycle.
// Load has priority over decrement; the count saturates at zero.
module sa_tile_sequencer_stream_counter
    import sa_tile_sequencer_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  cnt_t i_load_val,
    input  logic i_dec,
    output logic o_last
);

    cnt_t r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - cnt_t'(1);
        end
    end

    assign o_last = (r_cnt == cnt_t'(1));

endmodule

// File: rtl/sa_tile_sequencer.sv
// Walks instruction memory, running one clear/stream/commit pass per non-zero tile size.
// Outputs are registered from the next state so every strobe lines up with its state.
module sa_tile_sequencer
    import sa_tile_sequencer_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sa_tile_sequencer_if.slave   io_ctrl
);

    state_t r_state;
    state_t w_state_nxt;
    ptr_t   r_ptr;
    ptr_t   w_ptr_nxt;
    logic   w_cnt_load;
    logic   w_cnt_dec;
    logic   w_cnt_last;
    logic   w_start;

    logic   r_instr_rd;
    ptr_t   r_instr_addr;
    logic   r_in_clr;
    logic   r_a_rd;
    logic   r_b_rd;
    logic   r_sa_clr;
    logic   r_out_wr;
    ptr_t   r_out_tile;
    logic   r_out_rd_en;
    logic   r_busy;
    logic   r_ap_done;

    sa_tile_sequencer_stream_counter u_stream_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (tile_len(io_ctrl.instr_data)),
        .i_dec      (w_cnt_dec),
        .o_last     (w_cnt_last)
    );

    assign w_start = (r_state == IDLE) && io_ctrl.ap_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_ctrl.ap_start) begin
                    w_state_nxt = FETCH;
                    w_ptr_nxt   = '0;
                end
            end
            FETCH:  w_state_nxt = DECODE;
            DECODE: begin
                if (io_ctrl.instr_data == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR:  w_state_nxt = STREAM;
            STREAM: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_last) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                // The last tile slot ends the run instead of wrapping the pointer.
                if (r_ptr == ptr_t'(MAX_INSTR - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_ptr_nxt   = r_ptr + ptr_t'(1);
                    w_state_nxt = FETCH;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr_rd   <= 1'b0;
            r_instr_addr <= '0;
            r_in_clr     <= 1'b0;
            r_a_rd       <= 1'b0;
            r_b_rd       <= 1'b0;
            r_sa_clr     <= 1'b0;
            r_out_wr     <= 1'b0;
            r_out_tile   <= '0;
            r_busy       <= 1'b0;
            r_ap_done    <= 1'b0;
            r_out_rd_en  <= 1'b0;
        end else begin
            r_instr_rd   <= (w_state_nxt == FETCH);
            r_instr_addr <= (w_state_nxt == FETCH) ? w_ptr_nxt : '0;
            r_in_clr     <= (w_state_nxt == CLEAR);
            r_sa_clr     <= (w_state_nxt == CLEAR);
            r_a_rd       <= (w_state_nxt == STREAM);
            r_b_rd       <= (w_state_nxt == STREAM);
            r_out_wr     <= (w_state_nxt == WRITE);
            r_out_tile   <= (w_state_nxt == WRITE) ? r_ptr : '0;
            r_busy       <= (w_state_nxt != IDLE);
            // Done/readback are sticky levels, dropped only by an accepted start.
            if (w_state_nxt == DONE) begin
                r_ap_done   <= 1'b1;
                r_out_rd_en <= 1'b1;
            end else if (w_start) begin
                r_ap_done   <= 1'b0;
                r_out_rd_en <= 1'b0;
            end
        end
    end

    assign io_ctrl.instr_rd   = r_instr_rd;
    assign io_ctrl.instr_addr = r_instr_addr;
    assign io_ctrl.in_clr     = r_in_clr;
    assign io_ctrl.a_rd       = r_a_rd;
    assign io_ctrl.b_rd       = r_b_rd;
    assign io_ctrl.sa_clr     = r_sa_clr;
    assign io_ctrl.out_wr     = r_out_wr;
    assign io_ctrl.out_tile   = r_out_tile;
    assign io_ctrl.out_rd_en  = r_out_rd_en;
    assign io_ctrl.busy       = r_busy;
    assign io_ctrl.ap_done    = r_ap_done;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer: directed runs push expected fetch/write/done
// events; a negedge monitor pops and compares them as the DUT produces them.
module tb_sa_tile_sequencer;
    import sa_tile_sequencer_pkg::*;

    localparam int K_FETCH = 0;
    localparam int K_WRITE = 1;
    localparam int K_DONE  = 2;
    localparam int SN_OUTS = 0;
    localparam int SN_PEND = 1;

    typedef struct {
        int kind;
        int v1;
        int v2;
    } ev_t;

    typedef struct {
        int    kind;
        int    exp;
        string nm;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_tile_sequencer_if bus ();

    sa_tile_sequencer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_ctrl (bus)
    );

    instr_t imem [MAX_INSTR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.instr_data <= '0;
        else if (bus.instr_rd) bus.instr_data <= imem[bus.instr_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t   exp_q [$];
    snap_t snap_q [$];
    int    start_cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    run = 0;
    int    total = 0;
    int    clr_since = 0;
    int    conflicts = 0;
    logic  prev_done = 1'b0;

    function automatic int pk(bit busy, bit done, bit rden, bit ird, int ia,
                              bit inclr, bit sclr, bit ard, bit brd, bit owr, int ot);
        logic [14:0] v;
        v = {busy, done, rden, ird, ia[2:0], inclr, sclr, ard, brd, owr, ot[2:0]};
        return int'(v);
    endfunction

    function automatic int outs_now();
        return pk(bus.busy, bus.ap_done, bus.out_rd_en, bus.instr_rd, int'(bus.instr_addr),
                  bus.in_clr, bus.sa_clr, bus.a_rd, bus.b_rd, bus.out_wr, int'(bus.out_tile));
    endfunction

    function automatic string kname(input int k);
        if (k == K_FETCH) return "fetch";
        if (k == K_WRITE) return "write";
        return "done";
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic got(input int k, input int v1, input int v2);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({"unexpected_", kname(k)}, v1, -1);
            return;
        end
        e = exp_q.pop_front();
        chk({kname(e.kind), "_kind"}, k, e.kind);
        chk({kname(e.kind), "_v1"}, v1, e.v1);
        if (e.kind != K_FETCH) chk({kname(e.kind), "_v2"}, v2, e.v2);
    endtask

    // Monitor: owns all comparisons; stream length = a_rd cycles since the tile's sa_clr.
    always @(negedge clk) begin
        snap_t s;
        if (!rst_n) begin
            run = 0;
            total = 0;
            clr_since = 0;
            prev_done = 1'b0;
        end else begin
            if ((bus.a_rd != bus.b_rd) || (bus.a_rd && (bus.sa_clr || bus.out_wr)))
                conflicts++;
            if (bus.sa_clr) begin
                clr_since++;
                run = 0;
            end
            if (bus.a_rd) begin
                run++;
                total++;
            end
            if (bus.instr_rd) got(K_FETCH, int'(bus.instr_addr), 0);
            if (bus.out_wr) begin
                got(K_WRITE, int'(bus.out_tile), run);
                chk("sa_clr_per_tile", clr_since, 1);
                clr_since = 0;
            end
            if (bus.ap_done && !prev_done) begin
                got(K_DONE, cyc - start_cyc, total);
                chk("rd_overlap", conflicts, 0);
                total = 0;
            end
            prev_done = bus.ap_done;
        end
        while (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            if (s.kind == SN_OUTS) chk(s.nm, outs_now(), s.exp);
            else chk(s.nm, exp_q.size(), s.exp);
        end
    end

    // Instruction i sits in nibble i of w.
    task automatic load(input logic [31:0] w);
        for (int i = 0; i < MAX_INSTR; i++) imem[i] = w[i*4 +: 4];
    endtask

    task automatic expect_run(input int done_cyc);
        int tot;
        int p;
        tot = 0;
        for (p = 0; p < MAX_INSTR; p++) begin
            exp_q.push_back('{K_FETCH, p, 0});
            if (imem[p] == '0) break;
            exp_q.push_back('{K_WRITE, p, int'(imem[p]) + DRAIN});
            tot += int'(imem[p]) + DRAIN;
        end
        exp_q.push_back('{K_DONE, done_cyc, tot});
    endtask

    task automatic start();
        @(negedge clk);
        bus.ap_start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.ap_start = 1'b0;
        snap_q.push_back('{SN_OUTS, pk(1,0,0,1,0,0,0,0,0,0,0), "fetch0_outs"});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (bus.ap_done) break;
        end
        repeat (3) @(posedge clk);
        #1;
        snap_q.push_back('{SN_PEND, 0, "pending_events"});
        snap_q.push_back('{SN_OUTS, pk(0,1,1,0,0,0,0,0,0,0,0), "idle_after_done"});
        @(negedge clk);
        @(posedge clk);
    endtask

    initial begin
        bus.ap_start = 1'b0;
        load(32'h0);
        #1;
        snap_q.push_back('{SN_OUTS, 0, "reset_outs"});
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // [4,0]: done 17 edges after start (15-cycle tile + fetch/decode).
        load(32'h0000_0004);
        expect_run(17);
        start();
        wait_done();

        // [0]: done after fetch+decode.
        load(32'h0000_0000);
        expect_run(2);
        start();
        wait_done();

        // [2,15,3,0]: 13 + 26 + 14 + 2.
        load(32'h0000_03F2);
        expect_run(55);
        start();
        wait_done();

        // All ones: 8 tiles of 12 cycles, DONE straight after WRITE of tile 7.
        load(32'h1111_1111);
        expect_run(96);
        start();
        wait_done();

        // ap_start re-pulsed mid-STREAM must change nothing.
        load(32'h0000_0004);
        expect_run(17);
        start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.a_rd) break;
        end
        repeat (3) @(negedge clk);
        bus.ap_start = 1'b1;
        @(negedge clk);
        bus.ap_start = 1'b0;
        wait_done();

        // A pulse in IDLE clears ap_done and restarts at addr 0.
        expect_run(17);
        start();
        wait_done();

        // Async reset during tile 1's stream: tile 1 never written.
        load(32'h0000_0032);
        exp_q.push_back('{K_FETCH, 0, 0});
        exp_q.push_back('{K_WRITE, 0, 9});
        exp_q.push_back('{K_FETCH, 1, 0});
        start();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_wr) break;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.a_rd) break;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        snap_q.push_back('{SN_OUTS, 0, "async_reset_outs"});
        repeat (4) @(posedge clk);
        #1;
        snap_q.push_back('{SN_PEND, 0, "pending_after_reset"});
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        expect_run(29);
        start();
        wait_done();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
